// File: rtl/coin_travel_sequencer.sv
// Coin sprite travel sequencer.
// Draws, holds, erases and steps the coin between stations on the framebuffer.
module coin_travel_sequencer #(
    parameter int          SPRITE_W    = 4,
    parameter int          SPRITE_H    = 4,
    parameter int          FRAME_DIV   = 833333,
    parameter int          ROW_Y       = 56,
    parameter int          STATION0_X  = 4,
    parameter int          STATION1_X  = 40,
    parameter int          STATION2_X  = 76,
    parameter int          STATION3_X  = 112,
    parameter int          STATION4_X  = 148,
    parameter logic [2:0]  COIN_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] travel,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       plot,
    output logic       done_travel,
    output logic       busy
);

    localparam int WCW = $clog2(FRAME_DIV + 1);
    localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        WAIT,
        ERASE,
        DONE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       cur_x_q, cur_x_d;
    logic [7:0]       end_x_q, end_x_d;
    logic [PXW-1:0]   px_q, px_d;
    logic [PYW-1:0]   py_q, py_d;
    logic [WCW-1:0]   wait_q, wait_d;

    logic             code_ok;
    logic [7:0]       start_sel;
    logic [7:0]       end_sel;
    logic             px_last;
    logic             pix_last;
    logic             wait_last;

    // Only the four forward legs are recognised; anything else is ignored.
    always_comb begin
        code_ok = (travel == 3'b001) || (travel == 3'b010) ||
                  (travel == 3'b011) || (travel == 3'b101);
    end

    // Map the latched travel code to its start and destination columns.
    always_comb begin
        start_sel = 8'(STATION0_X);
        end_sel   = 8'(STATION1_X);
        case (code_q)
            3'b001: begin
                start_sel = 8'(STATION0_X);
                end_sel   = 8'(STATION1_X);
            end
            3'b010: begin
                start_sel = 8'(STATION1_X);
                end_sel   = 8'(STATION2_X);
            end
            3'b011: begin
                start_sel = 8'(STATION2_X);
                end_sel   = 8'(STATION3_X);
            end
            3'b101: begin
                start_sel = 8'(STATION3_X);
                end_sel   = 8'(STATION4_X);
            end
            default: begin
                start_sel = 8'(STATION0_X);
                end_sel   = 8'(STATION1_X);
            end
        endcase
    end

    // Scan position flags for the sprite footprint and the hold counter.
    always_comb begin
        px_last   = (px_q == PXW'(SPRITE_W - 1));
        pix_last  = px_last && (py_q == PYW'(SPRITE_H - 1));
        wait_last = (wait_q == WCW'(FRAME_DIV - 1));
    end

    // Next-state logic: draw / hold / erase / step until the destination.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cur_x_d = cur_x_q;
        end_x_d = end_x_q;
        px_d    = px_q;
        py_d    = py_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (code_ok) begin
                    code_d  = travel;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cur_x_d = start_sel;
                end_x_d = end_sel;
                px_d    = '0;
                py_d    = '0;
                wait_d  = '0;
                state_d = DRAW;
            end
            DRAW: begin
                if (pix_last) begin
                    px_d    = '0;
                    py_d    = '0;
                    wait_d  = '0;
                    state_d = WAIT;
                end else if (px_last) begin
                    px_d = '0;
                    py_d = py_q + PYW'(1);
                end else begin
                    px_d = px_q + PXW'(1);
                end
            end
            WAIT: begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = (cur_x_q == end_x_q) ? DONE : ERASE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            ERASE: begin
                if (pix_last) begin
                    px_d    = '0;
                    py_d    = '0;
                    cur_x_d = cur_x_q + 8'd1;
                    state_d = DRAW;
                end else if (px_last) begin
                    px_d = '0;
                    py_d = py_q + PYW'(1);
                end else begin
                    px_d = px_q + PXW'(1);
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (travel == 3'b000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            code_q  <= 3'b000;
            cur_x_q <= 8'd0;
            end_x_q <= 8'd0;
            px_q    <= '0;
            py_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cur_x_q <= cur_x_d;
            end_x_q <= end_x_d;
            px_q    <= px_d;
            py_q    <= py_d;
            wait_q  <= wait_d;
        end
    end

    // Moore outputs decoded from the registered state and scan counters.
    always_comb begin
        plot        = 1'b0;
        plot_x      = 8'd0;
        plot_y      = 7'd0;
        plot_colour = 3'b000;
        done_travel = (state_q == DONE);
        busy        = (state_q != IDLE);
        if (state_q == DRAW || state_q == ERASE) begin
            plot        = 1'b1;
            plot_x      = cur_x_q + 8'(px_q);
            plot_y      = 7'(ROW_Y) + 7'(py_q);
            plot_colour = (state_q == DRAW) ? COIN_COLOUR : BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_coin_travel_sequencer.sv
// Bench for coin_travel_sequencer.
// Compares every cycle against an expanded expected-output schedule.
module tb_coin_travel_sequencer;

    localparam int W    = 2;
    localparam int H    = 2;
    localparam int FD   = 3;
    localparam int ROWY = 56;
    localparam int COIN = 6;
    localparam int BG   = 0;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit done;
        bit busy;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] travel = 3'b000;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot;
    logic       done_travel;
    logic       busy;

    int st[5] = '{0, 4, 8, 12, 16};

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mst = 0;
    exp_t q[$];
    exp_t cur;

    int  nplot;
    int  ndone;
    int  minx;
    int  load_cyc;
    int  done_cyc;
    bit  seen_done;
    bit  prev_busy = 1'b0;

    coin_travel_sequencer #(
        .SPRITE_W(W),
        .SPRITE_H(H),
        .FRAME_DIV(FD),
        .ROW_Y(ROWY),
        .STATION0_X(0),
        .STATION1_X(4),
        .STATION2_X(8),
        .STATION3_X(12),
        .STATION4_X(16),
        .COIN_COLOUR(3'b110),
        .BG_COLOUR(3'b000)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .travel(travel),
        .plot_x(plot_x),
        .plot_y(plot_y),
        .plot_colour(plot_colour),
        .plot(plot),
        .done_travel(done_travel),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t mk(bit p, int x, int y, int c, bit d, bit b);
        exp_t e;
        e.plot = p;
        e.x    = x;
        e.y    = y;
        e.col  = c;
        e.done = d;
        e.busy = b;
        return e;
    endfunction

    function automatic int leg(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b011:  return 2;
            3'b101:  return 3;
            default: return -1;
        endcase
    endfunction

    // Expand one whole move into its per-cycle expected outputs.
    task automatic build(input int sx, input int ex);
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        for (int p = sx; p <= ex; p++) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++)
                    q.push_back(mk(1, p + xx, ROWY + yy, COIN, 0, 1));
            for (int w = 0; w < FD; w++)
                q.push_back(mk(0, 0, 0, 0, 0, 1));
            if (p != ex)
                for (int yy = 0; yy < H; yy++)
                    for (int xx = 0; xx < W; xx++)
                        q.push_back(mk(1, p + xx, ROWY + yy, BG, 0, 1));
        end
        q.push_back(mk(0, 0, 0, 0, 1, 1));
    endtask

    task automatic step();
        int l;
        @(posedge clock);
        cyc++;
        l = leg(travel);
        if (!resetn) begin
            mst = 0;
            q.delete();
            cur = mk(0, 0, 0, 0, 0, 0);
        end else if (mst == 0) begin
            if (l >= 0) begin
                build(st[l], st[l + 1]);
                cur = q.pop_front();
                mst = 1;
            end else begin
                cur = mk(0, 0, 0, 0, 0, 0);
            end
        end else if (mst == 1) begin
            if (q.size() == 0) begin
                mst = 2;
                cur = mk(0, 0, 0, 0, 0, 1);
            end else begin
                cur = q.pop_front();
            end
        end else begin
            if (travel == 3'b000) begin
                mst = 0;
                cur = mk(0, 0, 0, 0, 0, 0);
            end else begin
                cur = mk(0, 0, 0, 0, 0, 1);
            end
        end
        #1;
        check("plot", 32'(plot), 32'(cur.plot));
        check("plot_x", 32'(plot_x), cur.x);
        check("plot_y", 32'(plot_y), cur.y);
        check("colour", 32'(plot_colour), cur.col);
        check("done", 32'(done_travel), 32'(cur.done));
        check("busy", 32'(busy), 32'(cur.busy));
        if (plot) begin
            nplot++;
            if (int'(plot_x) < minx) minx = int'(plot_x);
        end
        if (busy && !prev_busy) load_cyc = cyc;
        if (done_travel) begin
            ndone++;
            seen_done = 1'b1;
            done_cyc = cyc;
        end
        prev_busy = busy;
    endtask

    task automatic clear_stats();
        nplot = 0;
        ndone = 0;
        minx = 255;
        seen_done = 1'b0;
        load_cyc = 0;
        done_cyc = 0;
    endtask

    task automatic run_to_done(input int bound);
        int n;
        n = 0;
        while (!seen_done && n < bound) begin
            step();
            n++;
        end
        if (!seen_done) check("timeout", 0, 1);
    endtask

    initial begin
        clear_stats();
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Reset in the middle of a move.
        travel = 3'b001;
        repeat (20) step();
        resetn = 1'b0;
        travel = 3'b000;
        step();
        check("rst_busy", 32'(busy), 0);
        resetn = 1'b1;
        repeat (5) step();
        check("rst_idle", 32'(busy), 0);

        // Full S0->S1 leg.
        clear_stats();
        travel = 3'b001;
        run_to_done(200);
        check("lat001", done_cyc - load_cyc, 52);
        check("plots001", nplot, 36);
        travel = 3'b000;
        repeat (2) step();

        // S1->S2 leg, erase ordering covered by the schedule.
        clear_stats();
        travel = 3'b010;
        run_to_done(200);
        check("minx010", minx, 4);
        travel = 3'b000;
        repeat (2) step();

        // Code held well past completion.
        clear_stats();
        travel = 3'b101;
        run_to_done(200);
        repeat (20) step();
        check("held_busy", 32'(busy), 1);
        check("held_pulses", ndone, 1);
        travel = 3'b000;
        repeat (3) step();
        check("held_idle", 32'(busy), 0);

        // Invalid code, then code switched mid-move.
        clear_stats();
        travel = 3'b100;
        repeat (10) step();
        check("inv_plot", nplot, 0);
        check("inv_busy", 32'(busy), 0);
        travel = 3'b011;
        repeat (10) step();
        travel = 3'b001;
        run_to_done(200);
        check("sw_pulses", ndone, 1);
        travel = 3'b000;
        repeat (2) step();

        // Back-to-back legs.
        clear_stats();
        travel = 3'b001;
        run_to_done(200);
        travel = 3'b000;
        step();
        step();
        clear_stats();
        travel = 3'b010;
        run_to_done(200);
        check("b2b_minx", minx, 4);
        travel = 3'b000;
        repeat (2) step();

        // Random travel codes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) travel = 3'b000;
                else travel = 3'($urandom_range(0, 7));
            end
            if (!resetn) resetn = 1'b1;
            else if ($urandom_range(0, 499) == 0) resetn = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
